// File: rtl/input_port.sv
// Serial 8N1 input port for a simple accumulator computer.
// Receives characters on rx, holds the last accepted one in INPR and
// signals it with FGI until the controller consumes it with clr_fgi.
// Overrun and framing errors are sticky until clr_err.
module input_port #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clr_fgi,
  input  logic       clr_err,
  output logic       FGI,
  output logic [7:0] INPR,
  output logic       ovr_err,
  output logic       frm_err,
  output logic       busy
);

  // Counter only needs to reach CLKS_PER_BIT-1, so it never wraps inside a bit.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
  logic          rx_meta_r;
  logic          rx_sync_r;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM plus character holding register, flag and error bookkeeping.
  // Clears come first so that a same-edge set or delivery further down wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      INPR    <= 8'h00;
      FGI     <= 1'b0;
      ovr_err <= 1'b0;
      frm_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (clr_fgi) begin
        FGI <= 1'b0;
      end
      if (clr_err) begin
        ovr_err <= 1'b0;
        frm_err <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            state_r <= START;
            cnt_r   <= '0;
            busy    <= 1'b1;
          end
        end

        START: begin
          // Mid-start-bit sample rejects glitches shorter than half a bit.
          if (cnt_r == HALF_LAST) begin
            cnt_r <= '0;
            if (!rx_sync_r) begin
              state_r <= DATA;
              idx_r   <= 3'd0;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt_r == BIT_LAST) begin
            shift_r <= {rx_sync_r, shift_r[7:1]};
            cnt_r   <= '0;
            idx_r   <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r <= '0;
            if (rx_sync_r) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              // A consume on the same edge frees the holding register.
              if (!FGI || clr_fgi) begin
                INPR <= shift_r;
                FGI  <= 1'b1;
              end else begin
                ovr_err <= 1'b1;
              end
            end else begin
              frm_err <= 1'b1;
              state_r <= WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        WAIT_IDLE: begin
          // Line stuck low after a bad stop bit; wait for it to go idle.
          if (rx_sync_r) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port.sv
// Directed testbench for input_port with hand-computed expectations.
module tb_input_port;

  localparam int C = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       clr_fgi;
  logic       clr_err;
  logic       FGI;
  logic [7:0] INPR;
  logic       ovr_err;
  logic       frm_err;
  logic       busy;

  int  n_cmp;
  int  n_fail;
  logic abort_tx;

  input_port #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .clr_fgi (clr_fgi),
    .clr_err (clr_err),
    .FGI     (FGI),
    .INPR    (INPR),
    .ovr_err (ovr_err),
    .frm_err (frm_err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one 8N1 frame; must be called at a falling edge, returns at one.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < C; k++) begin
        rx = abort_tx ? 1'b1 : frame[b];
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (FGI !== 1'b0)      begin n_fail++; $display("FAIL reset_fgi: got %b want 0", FGI); end
    if (INPR !== 8'h00)    begin n_fail++; $display("FAIL reset_inpr: got %h want 00", INPR); end
    if (ovr_err !== 1'b0)  begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ovr_err); end
    if (frm_err !== 1'b0)  begin n_fail++; $display("FAIL reset_frm: got %b want 0", frm_err); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp += 1;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_latency;
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400 && !seen; i++) begin
          @(posedge clk); #1;
          if (busy) seen = 1'b1;
        end
        if (seen) begin
          seen = 1'b0;
          for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); n++; #1;
            if (FGI) seen = 1'b1;
          end
        end
      end
    join
    n_cmp += 5;
    if (!seen || n != 152) begin n_fail++; $display("FAIL latency: got %0d edges (seen=%0d) want 152", n, seen); end
    if (INPR !== 8'hA5)   begin n_fail++; $display("FAIL a5_inpr: got %h want a5", INPR); end
    if (FGI !== 1'b1)     begin n_fail++; $display("FAIL a5_fgi: got %b want 1", FGI); end
    if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL a5_ovr: got %b want 0", ovr_err); end
    if (frm_err !== 1'b0) begin n_fail++; $display("FAIL a5_frm: got %b want 0", frm_err); end
    clr_fgi = 1'b1;
    @(negedge clk);
    clr_fgi = 1'b0;
    n_cmp += 2;
    if (FGI !== 1'b0)   begin n_fail++; $display("FAIL a5_clr_fgi: got %b want 0", FGI); end
    if (INPR !== 8'hA5) begin n_fail++; $display("FAIL a5_hold: got %h want a5", INPR); end
  endtask

  task automatic test_overrun;
    send_frame(8'h3C, 1'b1);
    n_cmp += 2;
    if (INPR !== 8'h3C) begin n_fail++; $display("FAIL ovr_first_inpr: got %h want 3c", INPR); end
    if (FGI !== 1'b1)   begin n_fail++; $display("FAIL ovr_first_fgi: got %b want 1", FGI); end
    send_frame(8'h7E, 1'b1);
    n_cmp += 3;
    if (INPR !== 8'h3C)   begin n_fail++; $display("FAIL ovr_inpr: got %h want 3c", INPR); end
    if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", ovr_err); end
    if (FGI !== 1'b1)     begin n_fail++; $display("FAIL ovr_fgi: got %b want 1", FGI); end
    clr_fgi = 1'b1;
    @(negedge clk);
    clr_fgi = 1'b0;
    n_cmp += 2;
    if (FGI !== 1'b0)     begin n_fail++; $display("FAIL ovr_clr_fgi: got %b want 0", FGI); end
    if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr_err); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp += 2;
    if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL ovr_clr_err: got %b want 0", ovr_err); end
    if (INPR !== 8'h3C)   begin n_fail++; $display("FAIL ovr_inpr_kept: got %h want 3c", INPR); end
  endtask

  task automatic test_framing;
    send_frame(8'hFF, 1'b0);
    repeat (20) @(negedge clk);
    n_cmp += 4;
    if (frm_err !== 1'b1) begin n_fail++; $display("FAIL frm_flag: got %b want 1", frm_err); end
    if (FGI !== 1'b0)     begin n_fail++; $display("FAIL frm_fgi: got %b want 0", FGI); end
    if (INPR !== 8'h3C)   begin n_fail++; $display("FAIL frm_inpr: got %h want 3c", INPR); end
    if (busy !== 1'b1)    begin n_fail++; $display("FAIL frm_wait_busy: got %b want 1", busy); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL frm_idle_busy: got %b want 0", busy); end
    if (frm_err !== 1'b1) begin n_fail++; $display("FAIL frm_sticky: got %b want 1", frm_err); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_cmp += 1;
    if (frm_err !== 1'b0) begin n_fail++; $display("FAIL frm_clr: got %b want 0", frm_err); end
  endtask

  task automatic test_false_start;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    n_cmp += 1;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fs_busy_high: got %b want 1", busy); end
    repeat (12) @(negedge clk);
    n_cmp += 5;
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL fs_busy_low: got %b want 0", busy); end
    if (FGI !== 1'b0)     begin n_fail++; $display("FAIL fs_fgi: got %b want 0", FGI); end
    if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL fs_ovr: got %b want 0", ovr_err); end
    if (frm_err !== 1'b0) begin n_fail++; $display("FAIL fs_frm: got %b want 0", frm_err); end
    if (INPR !== 8'h3C)   begin n_fail++; $display("FAIL fs_inpr: got %h want 3c", INPR); end
  endtask

  task automatic test_clr_on_stop;
    send_frame(8'h0F, 1'b1);
    n_cmp += 1;
    if (FGI !== 1'b1) begin n_fail++; $display("FAIL cos_pre_fgi: got %b want 1", FGI); end
    // Stop sample lands on the 155th rising edge after rx falls (2 sync + 1 + 152).
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        clr_fgi = 1'b1;
        @(negedge clk);
        clr_fgi = 1'b0;
      end
    join
    n_cmp += 3;
    if (INPR !== 8'h55)   begin n_fail++; $display("FAIL cos_inpr: got %h want 55", INPR); end
    if (FGI !== 1'b1)     begin n_fail++; $display("FAIL cos_fgi: got %b want 1", FGI); end
    if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL cos_ovr: got %b want 0", ovr_err); end
  endtask

  task automatic test_reset_midframe;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        // Start bit + 4 data bits = 80 clocks; 88 lands inside bit 4.
        repeat (88) @(posedge clk);
        @(negedge clk);
        n_cmp += 1;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre_busy: got %b want 1", busy); end
        abort_tx = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp += 5;
        if (FGI !== 1'b0)     begin n_fail++; $display("FAIL rm_fgi: got %b want 0", FGI); end
        if (INPR !== 8'h00)   begin n_fail++; $display("FAIL rm_inpr: got %h want 00", INPR); end
        if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL rm_ovr: got %b want 0", ovr_err); end
        if (frm_err !== 1'b0) begin n_fail++; $display("FAIL rm_frm: got %b want 0", frm_err); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    abort_tx = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_no_resume_busy: got %b want 0", busy); end
    if (FGI !== 1'b0)  begin n_fail++; $display("FAIL rm_no_resume_fgi: got %b want 0", FGI); end
    send_frame(8'h12, 1'b1);
    n_cmp += 3;
    if (INPR !== 8'h12)   begin n_fail++; $display("FAIL rm_inpr_12: got %h want 12", INPR); end
    if (FGI !== 1'b1)     begin n_fail++; $display("FAIL rm_fgi_12: got %b want 1", FGI); end
    if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL rm_ovr_12: got %b want 0", ovr_err); end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    abort_tx = 1'b0;
    rst      = 1'b1;
    rx       = 1'b1;
    clr_fgi  = 1'b0;
    clr_err  = 1'b0;
    test_reset();
    test_latency();
    test_overrun();
    test_framing();
    test_false_start();
    test_clr_on_stop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
